// File: rtl/mpi_master.sv
// mpi_master
//   Initiator for the multiplexed, active-low MPI bus. Turns one word/byte
//   request from a valid/ack port into a full bus cycle:
//   address phase, data phase and reply handshake, with a reply timeout.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   req, we, byte_en     request, 1=write, 1=byte write (writes only)
//   addr, wdata, sel     byte address, write data, active-low select code
//   ready                high only while idle (requests sampled then)
//   ack, err             one-cycle completion pulse, err=1 on reply timeout
//   rdata                read data, updated only by successful reads
//   ad_n                 inverted address/data bus, tristated when not driven
//   sel_n                latched select during a cycle, 2'b11 otherwise
//   sync_n, din_n, dout_n, wtbt_n   bus strobes, high when idle
//   rply_n               responder reply (pulled up on the board)
module mpi_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  sel,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  inout  wire  [15:0] ad_n,
  output logic [1:0]  sel_n,
  output logic        sync_n,
  output logic        din_n,
  output logic        dout_n,
  output logic        wtbt_n,
  input  logic        rply_n
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_SYNC, S_SETUP, S_STROBE, S_RELEASE, S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           abort_reg, abort_next;
  logic           we_reg, we_next;
  logic           byte_reg, byte_next;
  logic [15:0]    addr_reg, addr_next;
  logic [15:0]    data_reg, data_next;
  logic [1:0]     sel_reg, sel_next;
  logic [15:0]    rdata_reg, rdata_next;

  logic           ad_oe;
  logic [15:0]    ad_out;

  assign ad_n  = ad_oe ? ad_out : 16'hzzzz;
  assign rdata = rdata_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      abort_reg <= 1'b0;
      we_reg    <= 1'b0;
      byte_reg  <= 1'b0;
      addr_reg  <= 16'h0000;
      data_reg  <= 16'h0000;
      sel_reg   <= 2'b11;
      rdata_reg <= 16'h0000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      abort_reg <= abort_next;
      we_reg    <= we_next;
      byte_reg  <= byte_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      sel_reg   <= sel_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    // Counter falls back to zero on every transition, so entering STROBE
    // or RELEASE always starts a fresh wait count.
    cnt_next   = '0;
    abort_next = abort_reg;
    we_next    = we_reg;
    byte_next  = byte_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;
    rdata_next = rdata_reg;

    ready  = 1'b0;
    ack    = 1'b0;
    err    = 1'b0;
    sync_n = 1'b1;
    din_n  = 1'b1;
    dout_n = 1'b1;
    wtbt_n = 1'b1;
    sel_n  = 2'b11;
    ad_oe  = 1'b0;
    ad_out = 16'hffff;

    case (state_reg)
      S_IDLE: begin
        ready = 1'b1;
        if (req) begin
          we_next    = we;
          byte_next  = byte_en;
          addr_next  = addr;
          // Byte writes put the byte on both lanes; the responder picks
          // the lane from address bit 0.
          data_next  = byte_en ? {wdata[7:0], wdata[7:0]} : wdata;
          sel_next   = sel;
          abort_next = 1'b0;
          state_next = S_ADDR;
        end
      end

      S_ADDR, S_SYNC: begin
        sel_n  = sel_reg;
        ad_oe  = 1'b1;
        ad_out = ~addr_reg;
        wtbt_n = ~we_reg;
        if (state_reg == S_SYNC) begin
          sync_n     = 1'b0;
          state_next = S_SETUP;
        end else begin
          state_next = S_SYNC;
        end
      end

      S_SETUP, S_STROBE, S_RELEASE: begin
        sel_n  = sel_reg;
        sync_n = 1'b0;
        if (we_reg) begin
          ad_oe  = 1'b1;
          ad_out = ~data_reg;
          wtbt_n = ~byte_reg;
        end
        if (state_reg == S_SETUP) begin
          state_next = S_STROBE;
        end else if (state_reg == S_STROBE) begin
          din_n  = we_reg;
          dout_n = ~we_reg;
          if (!rply_n) begin
            if (!we_reg) rdata_next = ~ad_n;
            state_next = S_RELEASE;
          end else if (cnt_reg == CNT_LAST) begin
            abort_next = 1'b1;
            state_next = S_DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          // Strobe released; wait for the responder to drop its reply.
          if (rply_n) begin
            state_next = S_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            abort_next = 1'b1;
            state_next = S_DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      S_DONE: begin
        ack        = 1'b1;
        err        = abort_reg;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mpi_master.sv
// tb_mpi_master
//   Directed bench for mpi_master against a small RAM responder whose reply
//   delay is programmable. Expected values are hand-computed constants.
module tb_mpi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, byte_en;
  logic [15:0] addr, wdata;
  logic [1:0]  sel;
  logic        ready, ack, err;
  logic [15:0] rdata;
  wire  [15:0] ad_n;
  logic [1:0]  sel_n;
  logic        sync_n, din_n, dout_n, wtbt_n;
  logic        rply_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mpi_master #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .byte_en(byte_en),
    .addr(addr), .wdata(wdata), .sel(sel), .ready(ready), .ack(ack),
    .err(err), .rdata(rdata), .ad_n(ad_n), .sel_n(sel_n), .sync_n(sync_n),
    .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .rply_n(rply_n)
  );

  // ---------------- RAM responder ----------------
  logic [15:0] ram [0:255];
  logic [15:0] lat_addr = 16'h0000;
  logic        lat_sel  = 1'b0;
  logic        prev_sync = 1'b1;
  int          rcnt = 0;
  int          rdelay = 0;
  logic        strobe;

  assign strobe = !din_n || !dout_n;
  assign rply_n = !(lat_sel && strobe && (rcnt >= rdelay));
  assign ad_n   = (lat_sel && !din_n) ? ~ram[lat_addr[8:1]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sync_n && prev_sync) begin
      lat_addr <= ~ad_n;
      lat_sel  <= (sel_n == 2'b11);
    end
    prev_sync <= sync_n;
    if (!strobe) rcnt <= 0;
    else         rcnt <= rcnt + 1;
    if (lat_sel && !dout_n && !rply_n) begin
      if (!wtbt_n) begin
        if (lat_addr[0]) ram[lat_addr[8:1]][15:8] <= ~ad_n[15:8];
        else             ram[lat_addr[8:1]][7:0]  <= ~ad_n[7:0];
      end else begin
        ram[lat_addr[8:1]] <= ~ad_n;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] cap_ad_addr;
  logic        cap_wtbt;

  // Issues one request from an idle cycle; returns edges from acceptance to ack.
  task automatic run_txn(input logic t_we, input logic t_byte, input logic [15:0] t_addr,
                         input logic [15:0] t_wdata, input logic [1:0] t_sel,
                         output int lat, output logic t_err, output logic [15:0] t_rdata);
    req = 1'b1; we = t_we; byte_en = t_byte; addr = t_addr; wdata = t_wdata; sel = t_sel;
    @(posedge clk); #1;
    req = 1'b0;
    cap_ad_addr = ad_n;
    cap_wtbt = 1'b1;
    lat = 0;
    t_err = 1'b0;
    t_rdata = 16'h0000;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 3) cap_wtbt = wtbt_n;
      if (ack) begin
        lat = k; t_err = err; t_rdata = rdata;
        break;
      end
    end
    @(posedge clk); #1;
    $display("txn we=%0b byte=%0b addr=%h wdata=%h sel=%b -> lat=%0d err=%0b rdata=%h",
             t_we, t_byte, t_addr, t_wdata, t_sel, lat, t_err, t_rdata);
  endtask

  int          lat;
  logic        terr;
  logic [15:0] trd;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; byte_en = 1'b0;
    addr = 16'h0000; wdata = 16'h0000; sel = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_strobes", {sync_n, din_n, dout_n, wtbt_n}, 4'b1111);
    chk("rst_sel_n", sel_n, 2'b11);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word write then read back
    run_txn(1'b1, 1'b0, 16'h0100, 16'h1234, 2'b11, lat, terr, trd);
    chk("wr_addr_phase", cap_ad_addr, 16'hFEFF);
    chk("wr_lat", lat, 5);
    chk("wr_err", terr, 0);
    chk("wr_wtbt_strobe", cap_wtbt, 1);
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, lat, terr, trd);
    chk("rd_lat", lat, 5);
    chk("rd_err", terr, 0);
    chk("rd_data", trd, 16'h1234);

    // Byte writes to each lane
    run_txn(1'b1, 1'b1, 16'h0101, 16'h00AB, 2'b11, lat, terr, trd);
    chk("bw_hi_lat", lat, 5);
    chk("bw_hi_wtbt", cap_wtbt, 0);
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, lat, terr, trd);
    chk("rd_after_hi", trd, 16'hAB34);
    run_txn(1'b1, 1'b1, 16'h0100, 16'h00CD, 2'b11, lat, terr, trd);
    chk("bw_lo_wtbt", cap_wtbt, 0);
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, lat, terr, trd);
    chk("rd_after_lo", trd, 16'hABCD);

    // Unselected responder: timeout
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b00, lat, terr, trd);
    chk("to_lat", lat, 67);
    chk("to_err", terr, 1);
    chk("to_rdata", trd, 16'hABCD);
    chk("to_idle_strobes", {sync_n, din_n, dout_n, wtbt_n}, 4'b1111);
    chk("to_idle_sel", sel_n, 2'b11);
    chk("to_idle_ready", ready, 1);

    // Slow responder: 10 wait cycles
    rdelay = 10;
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, lat, terr, trd);
    chk("slow_lat", lat, 15);
    chk("slow_err", terr, 0);
    chk("slow_data", trd, 16'hABCD);
    rdelay = 0;

    // Reset during STROBE of a write
    req = 1'b1; we = 1'b1; byte_en = 1'b0; addr = 16'h0102; wdata = 16'h5555; sel = 2'b11;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_in_strobe", dout_n, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_ready", ready, 1);
    chk("mid_ack", ack, 0);
    chk("mid_err", err, 0);
    chk("mid_rdata", rdata, 16'h0000);
    chk("mid_strobes", {sync_n, din_n, dout_n, wtbt_n}, 4'b1111);
    chk("mid_sel_n", sel_n, 2'b11);
    begin
      int acks_seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (ack) acks_seen++;
      end
      chk("mid_no_ack", acks_seen, 0);
    end
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000, 2'b11, lat, terr, trd);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_data", trd, 16'hABCD);

    // Back-to-back writes with req held high
    begin
      int acc [3];
      int n = 0;
      int acks_seen = 0;
      int gap = 0;
      int min_gap = 99;
      logic seen_low = 1'b0;
      req = 1'b1; we = 1'b1; byte_en = 1'b0; addr = 16'h0110; wdata = 16'h7777; sel = 2'b11;
      for (int cyc = 0; cyc < 30; cyc++) begin
        if (n == 3) req = 1'b0;
        if (req && ready) begin
          acc[n] = cyc;
          n++;
        end
        if (ack) acks_seen++;
        if (!sync_n) begin
          if (seen_low && gap > 0 && gap < min_gap) min_gap = gap;
          seen_low = 1'b1;
          gap = 0;
        end else begin
          gap++;
        end
        @(posedge clk); #1;
      end
      req = 1'b0;
      $display("b2b accepts=%0d at %0d,%0d,%0d acks=%0d min_sync_gap=%0d",
               n, acc[0], acc[1], acc[2], acks_seen, min_gap);
      chk("b2b_count", n, 3);
      chk("b2b_gap1", acc[1] - acc[0], 7);
      chk("b2b_gap2", acc[2] - acc[1], 7);
      chk("b2b_acks", acks_seen, 3);
      chk("b2b_sync_gap", (min_gap >= 2) ? 1 : 0, 1);
    end
    run_txn(1'b0, 1'b0, 16'h0110, 16'h0000, 2'b11, lat, terr, trd);
    chk("b2b_readback", trd, 16'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mpi_master.md
# mpi_master

Bus initiator for the 1801VM1-style multiplexed, active-low MPI bus (`ad_n`, `sync_n`, `din_n`, `dout_n`, `wtbt_n`, `rply_n`, `sel_n`). It converts single-word or single-byte requests from a simple valid/ack port into a full bus cycle: address phase, data phase and reply handshake, with a reply timeout. It sits in the testbench and DMA paths wherever something other than the CPU must master the bus, including word and byte writes, against memories and peripherals.

## Interface
- `TIMEOUT`, 64: max cycles spent waiting for each `rply_n` edge; ≥2.
- `clk`  in  1  single clock; all state changes on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  1  transaction request; sampled only while `ready`=1.
- `we`  in  1  1 = write, 0 = read.
- `byte_en`  in  1  write only: 1 = byte write, 0 = word write.
- `addr`  in  16  byte address; bit 0 selects the lane on byte writes.
- `wdata`  in  16  write data; a byte write uses `wdata[7:0]`.
- `sel`  in  2  active-low select code driven on `sel_n`; 2'b11 = memory.
- `ready`  out  1  high only in IDLE.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ack`; 1 = reply timeout.
- `rdata`  out  16  read data; updated only on successful reads.
- `ad_n`  inout  16  bus address/data, inverted; tristated when not driven.
- `sel_n`  out  2  latched `sel` during a cycle, 2'b11 otherwise.
- `sync_n`, `din_n`, `dout_n`, `wtbt_n`  out  1 each  bus strobes, driven high when idle.
- `rply_n`  in  1  responder reply; bench pulls it up, so Z reads as 1.

## Operation
- States: IDLE, ADDR, SYNC, SETUP, STROBE, RELEASE, DONE.
- IDLE: when `req`=1, latch `we`, `byte_en`, `addr`, `wdata` and `sel`, then go to ADDR.
- ADDR: drive `ad_n`=~addr and `wtbt_n`=~we; `sync_n`=1. Lasts 1 cycle.
- SYNC: `sync_n`=0, which is the responder's latch edge. Address stays driven for this cycle as hold time. Lasts 1 cycle.
- SETUP: `sync_n` stays 0.
  - Read: release `ad_n`; `wtbt_n`=1.
  - Write: drive `ad_n`=~data and `wtbt_n`=~byte_en. For byte writes, data = {wdata[7:0], wdata[7:0]} (both lanes).
  - Lasts 1 cycle.
- STROBE: `din_n`=0 (read) or `dout_n`=0 (write). Clear the counter on entry.
  - If `rply_n`=0 is sampled: on a read, `rdata`<=~ad_n; go to RELEASE.
  - Otherwise increment the counter. If the counter reaches TIMEOUT-1 without a reply, set the abort flag and go to DONE.
- RELEASE: deassert the strobe. Write data stays driven. Clear the counter on entry.
  - Go to DONE when `rply_n`≠0.
  - Timeout handling is the same as STROBE: abort after TIMEOUT cycles.
- DONE: `sync_n`=1, `ad_n` released, `wtbt_n`=1, `sel_n`=2'b11. Pulse `ack`; `err`=abort flag. Go to IDLE.
- `sync_n` is never deasserted while `din_n` or `dout_n` is low.
- `ad_n` is never driven while `din_n` is low.
- Rules for `rdata`:
  - On an aborted read, `rdata` is left unchanged.
  - A byte read returns the full word; the requester extracts the byte.

## Timing
- Reset (`rst_n`=0 at an edge), including mid-transaction, puts the block in this state from the next cycle:
  - state IDLE, `ready`=1, `ack`=0, `err`=0, `rdata`=16'h0000;
  - `sync_n`=`din_n`=`dout_n`=`wtbt_n`=1, `sel_n`=2'b11, `ad_n` Z;
  - the counter and abort flag are cleared; no `ack` is issued for the aborted cycle.
- Zero-wait responder (one whose `rply_n` responds combinationally to the strobe): for a request accepted at edge E, DONE is entered at E+5 and `ack` is high in the cycle after E+5.
- Each wait cycle in STROBE or RELEASE adds 1 to that latency.
- Back-to-back requests with `req` held high are accepted every 7 edges.
- Timeout with no reply: `ack`=1 with `err`=1 at E+3+TIMEOUT.
- `req` while `ready`=0 is ignored and is not queued.

## Test plan
- Word write 16'h1234 to 16'h0100, then a read of 16'h0100, against the bench RAM responder:
  - `ad_n`=16'hFEFF during ADDR;
  - each `ack` arrives 5 edges after acceptance;
  - the read returns `rdata`=16'h1234 with `err`=0.
- Byte write 16'h00AB to 16'h0101, then a read of 16'h0100 → 16'hAB34. Byte write 16'h00CD to 16'h0100, then a read → 16'hABCD. `wtbt_n`=0 during the strobe.
- `sel`=2'b00 (RAM not selected, `rply_n` floats high), read with TIMEOUT=64:
  - `ack`=1 and `err`=1 at E+67;
  - `rdata` unchanged;
  - bus idle afterwards.
- Responder delays `rply_n` by 10 cycles after `din_n`=0 → `ack` at E+15 with correct data, `err`=0.
- `rst_n`=0 for one edge while in STROBE of a write → all outputs at reset values the next cycle, no `ack`. A following read then completes normally.
- `req` held high for 3 writes → acceptances at E, E+7, E+14; `sync_n` high ≥2 cycles between cycles.
